// File: rtl/alu32_vec_capture_if.sv
// alu32_vec_capture_if
// Bundles the capture side (ALU tuple + cap_valid/cap_ready), the byte
// stream side (out_valid/out_ready/out_data/out_last) and the status
// outputs (count, dropped) of alu32_vec_capture.
//   slave  : the capture block itself (consumes tuples, produces bytes)
//   master : whatever drives tuples and sinks bytes (ALU tap + dumper)
interface alu32_vec_capture_if #(
    parameter int ADDR_W = 4
);
    logic              cap_valid;
    logic              cap_ready;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [2:0]        op;
    logic [31:0]       result;
    logic              c;
    logic              n;
    logic              z;
    logic              v;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [ADDR_W:0]   count;
    logic [15:0]       dropped;

    modport slave (
        input  cap_valid, a, b, op, result, c, n, z, v, out_ready,
        output cap_ready, out_valid, out_data, out_last, count, dropped
    );

    modport master (
        output cap_valid, a, b, op, result, c, n, z, v, out_ready,
        input  cap_ready, out_valid, out_data, out_last, count, dropped
    );
endinterface

// File: rtl/alu32_vec_capture.sv
// alu32_vec_capture
// Taps an alu32 instance, packs each captured operand/opcode/result/flag
// tuple into a 104-bit test vector, queues the vectors in a FIFO and
// streams them out MSB-first as 13 bytes per vector.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : alu32_vec_capture_if.slave
//            cap_valid/cap_ready + a/b/op/result/c/n/z/v  (capture side)
//            out_valid/out_ready/out_data/out_last        (byte stream)
//            count (vectors held), dropped (refused captures, saturating)
// Vector layout [103:0]: a, b, 1'b0, op, result, c, n, z, v.
module alu32_vec_capture #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    alu32_vec_capture_if.slave    bus
);
    localparam int               VEC_W    = 104;
    localparam int               NBYTES   = 13;
    localparam logic [3:0]       LAST_IDX = 4'd12;
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       dropped_q, dropped_d;

    logic [VEC_W-1:0]  mem [DEPTH];
    logic [VEC_W-1:0]  cap_vec;
    logic [VEC_W-1:0]  head_vec;
    logic [7:0]        head_bytes [NBYTES];

    logic full, empty, push, fire, pop;

    // The pad bit makes op occupy a whole hex digit in the .tv file.
    assign cap_vec = {bus.a, bus.b, 1'b0, bus.op, bus.result,
                      bus.c, bus.n, bus.z, bus.v};

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign push = bus.cap_valid && !full;
    assign fire = !empty && bus.out_ready;
    assign pop  = fire && (byte_idx_q == LAST_IDX);

    assign bus.cap_ready = !full;
    assign bus.out_valid = !empty;
    assign bus.out_last  = !empty && (byte_idx_q == LAST_IDX);
    assign bus.count     = count_q;
    assign bus.dropped   = dropped_q;

    // Vector storage: no reset, write-only on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= cap_vec;
        end
    end

    assign head_vec = mem[rptr_q];

    // Byte 0 is the most significant byte of the head vector.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign head_bytes[gi] = head_vec[VEC_W-1-8*gi -: 8];
        end
    endgenerate

    // Masked while empty so the stream reads 0x00 after reset even though
    // the RAM holds stale or undefined data.
    assign bus.out_data = empty ? 8'h00 : head_bytes[byte_idx_q];

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        dropped_d  = dropped_q;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (fire) begin
            byte_idx_d = (byte_idx_q == LAST_IDX) ? 4'd0 : byte_idx_q + 4'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.cap_valid && full && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            dropped_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            dropped_q  <= dropped_d;
        end
    end
endmodule
